systolic_feeder: RTL
====================

# systolic_feeder

Operand feeder for the N×N systolic MAC array. It stores one A tile (row operands) and one B tile (column operands). On start it pulses an array clear, then drives diagonally skewed, zero-padded operand streams into the west and north edges of the array. When the final product has been accumulated in the far-corner PE, it pulses done.

## Interface
Parameters:
- N, 4: array dimension; tiles are N×N.
- DW, 8: operand width, signed.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for one tile element.
- wr_sel  in  1  target tile: 0 = A, 1 = B.
- wr_row  in  $clog2(N)  element row index.
- wr_col  in  $clog2(N)  element column index.
- wr_data  in  DW  signed element value.
- start  in  1  request a tile computation.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse; array results are final.
- array_clr  out  1  one-cycle active-high clear for the PE array.
- west  out  N×DW  signed; west[i] drives row i of the array.
- north  out  N×DW  signed; north[j] drives column j of the array.

## Operation
- FSM states: IDLE, CLEAR, STREAM, DONE.
- IDLE → CLEAR: on start. In CLEAR, array_clr = 1 and west/north = 0.
- CLEAR → STREAM: unconditional.
- STREAM lasts 3N−2 cycles, indexed t = 0..3N−3.
  - west[i] = A[i][t−i] when 0 ≤ t−i < N, else 0.
  - north[j] = B[t−j][j] when 0 ≤ t−j < N, else 0.
- STREAM → DONE after t = 3N−3. DONE asserts done = 1 for one cycle, then returns to IDLE.
- Skew schedule: PE(i,j) receives A[i][k] and B[k][j] together at stream cycle i+j+k. The last operand pair reaches PE(N−1,N−1) at t = 3N−3 and is accumulated on that cycle's closing edge.
- West and north outputs are zero in every cycle outside STREAM.
- Tile writes are accepted in IDLE only; writes in CLEAR, STREAM or DONE are dropped (single-bank build).
- wr_en and start in the same IDLE cycle: the write completes and is included in the stream.
- start while busy is ignored; it is not queued.
- Tile contents persist across runs; a rerun without writes reproduces the same streams.
- Reset, including mid-stream: state = IDLE; busy, done, array_clr = 0; west/north = 0; both tiles cleared to 0.

## Timing
- start is sampled on edge E. CLEAR occupies cycle E+1; STREAM occupies E+2 .. E+3N−1; done is high in cycle E+3N.
- Total latency from start to done is 3N cycles. For N = 4 that is 12.
- west, north, array_clr and done are all registered outputs, with no combinational path from inputs.
- busy rises in cycle E+1 and falls after the done cycle. A new start is accepted in cycle E+3N+1.

## Configuration
- SYSTOLIC_FEEDER_DBUF_EN defined:
  - Two banks per tile; the FSM streams from the active bank.
  - Writes always target the shadow bank and are accepted in every state.
  - On an accepted start, the banks swap before CLEAR. A write in the start cycle lands in the bank that becomes active.
  - Reset clears both banks and selects bank 0 as active.
- Not defined: a single bank; writes outside IDLE are dropped, as described under Operation.

## Structure
- npu_pkg holds:
  - default N and DW;
  - the feeder_state_t enum (IDLE, CLEAR, STREAM, DONE);
  - the wr_sel encodings SEL_A and SEL_B;
  - the localparam STREAM_LEN = 3N−2.
- Sub-module operand_bank holds the N×N tile storage. It has one write port and N combinational read ports, each indexed by a row and a column. Two instances are used (A and B), or four under SYSTOLIC_FEEDER_DBUF_EN. The top level holds the FSM, the t counter and the skew/zero-pad logic.

## Test plan
- N=2; write A = [[1,2],[3,4]] and B = [[5,6],[7,8]]; start → array_clr high for 1 cycle, then over the four STREAM cycles:
  - west[0] = 1,2,0,0 and west[1] = 0,3,4,0;
  - north[0] = 5,7,0,0 and north[1] = 0,6,8,0;
  - done in the 6th cycle after the start edge.
- Same stimulus with a 2×2 PE array attached → at done, results are C = [[19,22],[43,50]].
- N=4, A = identity, B[r][c] = 4r+c → done exactly 12 cycles after start; C equals B; a second start without writes yields identical streams.
- Assert rst_n low at stream t = 3 → next cycle: IDLE, all outputs 0, busy = 0; a subsequent start streams all-zero operands.
- start pulsed during STREAM, and wr_en of A[0][0] = −7 during STREAM (single bank) → neither takes effect: done count stays 1 and the next run still streams the old A[0][0]. Under SYSTOLIC_FEEDER_DBUF_EN the write is accepted and −7 appears only after the following start.
- A[1][1] = −128, B[1][1] = −128 with all other elements 0 → west/north carry −128 with sign preserved at t = 2; the attached PE(1,1) accumulates +16384.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and defaults for the systolic MAC array feeder.
// Holds the feeder FSM encoding, tile-select encodings and default dimensions.
package npu_pkg;

  localparam int N_DEF      = 4;
  localparam int DW_DEF     = 8;
  localparam int STREAM_LEN = 3 * N_DEF - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/systolic_feeder_bank.sv
// operand_bank: N x N tile storage, one write port and N combinational read ports.
// Cleared to zero by the asynchronous reset.
module operand_bank
  import npu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_wr_row,
  input  logic [AW-1:0]         i_wr_col,
  input  logic [DW-1:0]         i_wr_data,
  input  logic [N-1:0][AW-1:0]  i_rd_row,
  input  logic [N-1:0][AW-1:0]  i_rd_col,
  output logic [N-1:0][DW-1:0]  o_rd_data
);

  logic [DW-1:0] r_mem [N][N];

  // Tile storage with single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  // Independent combinational read ports.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      o_rd_data[p] = r_mem[i_rd_row[p]][i_rd_col[p]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Skewed, zero-padded operand feeder for an N x N systolic MAC array.
// Define SYSTOLIC_FEEDER_DBUF_EN for double-buffered tiles (writes to shadow bank, swap on start).
module systolic_feeder
  import npu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 array_clr,
  output logic [N-1:0][DW-1:0] west,
  output logic [N-1:0][DW-1:0] north
);

  localparam int AW  = $clog2(N);
  localparam int LEN = 3 * N - 2;
  localparam int TW  = $clog2(LEN);

  feeder_state_t r_state, w_next_state;
  logic [TW-1:0] r_t, w_next_t;
  logic          w_start_acc;

  logic [N-1:0][AW-1:0] w_a_row, w_a_col, w_b_row, w_b_col;
  logic [N-1:0][DW-1:0] w_a_data, w_b_data;
  logic [N-1:0][DW-1:0] w_west_nxt, w_north_nxt;
  logic [N-1:0]         w_a_ok, w_b_ok;

  logic                 r_busy, r_done, r_clr;
  logic [N-1:0][DW-1:0] r_west, r_north;

  assign w_start_acc = (r_state == IDLE) && start;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic                 r_active;
  logic [N-1:0][DW-1:0] w_a0_data, w_a1_data, w_b0_data, w_b1_data;
  logic                 w_we_a0, w_we_a1, w_we_b0, w_we_b1;

  // Active-bank pointer; flips on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
    end else if (w_start_acc) begin
      r_active <= ~r_active;
    end
  end

  // Writes land in the shadow bank, which is the one not currently active.
  assign w_we_a0  = wr_en && (wr_sel == SEL_A) &&  r_active;
  assign w_we_a1  = wr_en && (wr_sel == SEL_A) && !r_active;
  assign w_we_b0  = wr_en && (wr_sel == SEL_B) &&  r_active;
  assign w_we_b1  = wr_en && (wr_sel == SEL_B) && !r_active;
  assign w_a_data = r_active ? w_a1_data : w_a0_data;
  assign w_b_data = r_active ? w_b1_data : w_b0_data;

  operand_bank #(.N(N), .DW(DW)) u_bank_a0 (
    .clk(clk), .rst_n(rst_n), .i_we(w_we_a0), .i_wr_row(wr_row), .i_wr_col(wr_col),
    .i_wr_data(wr_data), .i_rd_row(w_a_row), .i_rd_col(w_a_col), .o_rd_data(w_a0_data));
  operand_bank #(.N(N), .DW(DW)) u_bank_a1 (
    .clk(clk), .rst_n(rst_n), .i_we(w_we_a1), .i_wr_row(wr_row), .i_wr_col(wr_col),
    .i_wr_data(wr_data), .i_rd_row(w_a_row), .i_rd_col(w_a_col), .o_rd_data(w_a1_data));
  operand_bank #(.N(N), .DW(DW)) u_bank_b0 (
    .clk(clk), .rst_n(rst_n), .i_we(w_we_b0), .i_wr_row(wr_row), .i_wr_col(wr_col),
    .i_wr_data(wr_data), .i_rd_row(w_b_row), .i_rd_col(w_b_col), .o_rd_data(w_b0_data));
  operand_bank #(.N(N), .DW(DW)) u_bank_b1 (
    .clk(clk), .rst_n(rst_n), .i_we(w_we_b1), .i_wr_row(wr_row), .i_wr_col(wr_col),
    .i_wr_data(wr_data), .i_rd_row(w_b_row), .i_rd_col(w_b_col), .o_rd_data(w_b1_data));
`else
  logic w_we_a, w_we_b;

  assign w_we_a = wr_en && (wr_sel == SEL_A) && (r_state == IDLE);
  assign w_we_b = wr_en && (wr_sel == SEL_B) && (r_state == IDLE);

  operand_bank #(.N(N), .DW(DW)) u_bank_a (
    .clk(clk), .rst_n(rst_n), .i_we(w_we_a), .i_wr_row(wr_row), .i_wr_col(wr_col),
    .i_wr_data(wr_data), .i_rd_row(w_a_row), .i_rd_col(w_a_col), .o_rd_data(w_a_data));
  operand_bank #(.N(N), .DW(DW)) u_bank_b (
    .clk(clk), .rst_n(rst_n), .i_we(w_we_b), .i_wr_row(wr_row), .i_wr_col(wr_col),
    .i_wr_data(wr_data), .i_rd_row(w_b_row), .i_rd_col(w_b_col), .o_rd_data(w_b_data));
`endif

  // FSM state and stream index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_next_state;
      r_t     <= w_next_t;
    end
  end

  // Next-state and next stream index.
  always_comb begin
    w_next_state = r_state;
    w_next_t     = '0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = CLEAR;
        else       w_next_state = IDLE;
      end
      CLEAR: w_next_state = STREAM;
      STREAM: begin
        if (r_t == TW'(LEN - 1)) begin
          w_next_state = DONE;
        end else begin
          w_next_state = STREAM;
          w_next_t     = r_t + TW'(1);
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Read addresses for the next cycle's stream index; outputs are registered from these.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      w_a_row[p] = AW'(p);
      w_a_col[p] = AW'(int'(w_next_t) - p);
      w_b_row[p] = AW'(int'(w_next_t) - p);
      w_b_col[p] = AW'(p);
      w_a_ok[p]  = (w_next_state == STREAM) && (int'(w_next_t) >= p) && ((int'(w_next_t) - p) < N);
      w_b_ok[p]  = w_a_ok[p];
    end
  end

  // Zero-pad lanes outside their diagonal window.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      w_west_nxt[p]  = w_a_ok[p] ? w_a_data[p] : '0;
      w_north_nxt[p] = w_b_ok[p] ? w_b_data[p] : '0;
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      r_west  <= '0;
      r_north <= '0;
    end else begin
      r_busy  <= (w_next_state != IDLE);
      r_done  <= (w_next_state == DONE);
      r_clr   <= (w_next_state == CLEAR);
      r_west  <= w_west_nxt;
      r_north <= w_north_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign array_clr = r_clr;
  assign west      = r_west;
  assign north     = r_north;

endmodule
